// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: BT.601 full-range coefficients and fixed-point types shared by the YCbCr/RGB stages
package ycbcr_pkg;
  localparam int FRAC_W = 10;
  localparam int COEF_W = 13;
  localparam int ACC_W  = 24;
  localparam logic signed [COEF_W-1:0] K_RCR = 13'sd1436;
  localparam logic signed [COEF_W-1:0] K_GCB = 13'sd352;
  localparam logic signed [COEF_W-1:0] K_GCR = 13'sd731;
  localparam logic signed [COEF_W-1:0] K_BCB = 13'sd1815;
  typedef logic signed [8:0] dchroma_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  localparam dchroma_t C_OFF = 9'sd128;
  localparam acc_t RND = 24'sd512;
endpackage

// File: rtl/ycbcr2rgb_sat.sv
// ycbcr2rgb_sat: drops Q10 fraction and clamps to 0..255; clip output only with YCBCR2RGB_CLIP_FLAG_EN
module ycbcr2rgb_sat
  import ycbcr_pkg::*;
(
  input  logic signed [ACC_W-1:0] s,
  output logic [7:0] q
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  , output logic clip
`endif
);
  logic signed [ACC_W-1:0] sh;
  logic lo, hi;
  assign sh = s >>> FRAC_W;
  assign lo = sh[ACC_W-1];
  assign hi = !lo && |sh[ACC_W-2:8];
  assign q = lo ? 8'd0 : hi ? 8'hff : sh[7:0];
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  assign clip = lo | hi;
`endif
endmodule

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage BT.601 full-range YCbCr to RGB converter with clock enable.
// Optional clamp indicator oClip under YCBCR2RGB_CLIP_FLAG_EN.
module ycbcr2rgb
  import ycbcr_pkg::*;
(
  input  logic iClk,
  input  logic iRst,
  input  logic iCe,
  input  logic iValid,
  input  logic [7:0] iY,
  input  logic [7:0] iCb,
  input  logic [7:0] iCr,
  output logic oValid,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  , output logic oClip
`endif
);
  logic [7:0] y1;
  dchroma_t dcb1, dcr1;
  logic v1, v2, v3;
  acc_t ysh2, prcr2, pgcb2, pgcr2, pbcb2, sr3, sg3, sb3;
  logic [7:0] r4, g4, b4;
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  logic cr4, cg4, cb4;
  ycbcr2rgb_sat u_r (.s(sr3), .q(r4), .clip(cr4));
  ycbcr2rgb_sat u_g (.s(sg3), .q(g4), .clip(cg4));
  ycbcr2rgb_sat u_b (.s(sb3), .q(b4), .clip(cb4));
`else
  ycbcr2rgb_sat u_r (.s(sr3), .q(r4));
  ycbcr2rgb_sat u_g (.s(sg3), .q(g4));
  ycbcr2rgb_sat u_b (.s(sb3), .q(b4));
`endif
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      y1 <= '0;
      dcb1 <= '0;
      dcr1 <= '0;
      v1 <= 1'b0;
      ysh2 <= '0;
      prcr2 <= '0;
      pgcb2 <= '0;
      pgcr2 <= '0;
      pbcb2 <= '0;
      v2 <= 1'b0;
      sr3 <= '0;
      sg3 <= '0;
      sb3 <= '0;
      v3 <= 1'b0;
      oR <= '0;
      oG <= '0;
      oB <= '0;
      oValid <= 1'b0;
`ifdef YCBCR2RGB_CLIP_FLAG_EN
      oClip <= 1'b0;
`endif
    end else if (iCe) begin
      y1 <= iY;
      dcb1 <= $signed({1'b0, iCb}) - C_OFF;
      dcr1 <= $signed({1'b0, iCr}) - C_OFF;
      v1 <= iValid;
      ysh2 <= acc_t'(y1) <<< FRAC_W;
      prcr2 <= acc_t'(K_RCR) * acc_t'(dcr1);
      pgcb2 <= acc_t'(K_GCB) * acc_t'(dcb1);
      pgcr2 <= acc_t'(K_GCR) * acc_t'(dcr1);
      pbcb2 <= acc_t'(K_BCB) * acc_t'(dcb1);
      v2 <= v1;
      sr3 <= ysh2 + prcr2 + RND;
      sg3 <= ysh2 - pgcb2 - pgcr2 + RND;
      sb3 <= ysh2 + pbcb2 + RND;
      v3 <= v2;
      oR <= r4;
      oG <= g4;
      oB <= b4;
      oValid <= v3;
`ifdef YCBCR2RGB_CLIP_FLAG_EN
      oClip <= v3 & (cr4 | cg4 | cb4);
`endif
    end
  end
endmodule
